// File: rtl/zint_pri.sv
// Z80 IM2 interrupt controller: latches per-source start strobes, drives the
// shared open-drain ~INT line and presents the IM2 vector of the acked source.
module zint_pri #(
   parameter int         NSRC       = 4,
   parameter logic [7:0] VECT_BASE  = 8'hFF,
   parameter int         VECT_STEP  = 2,
   parameter int         PULSE_LEN  = 32,
   parameter logic [7:0] PULSE_MASK = 8'h01,
   parameter logic [7:0] VDOS_LOSE  = 8'h03,
   localparam int        SW         = (NSRC > 1) ? $clog2(NSRC) : 1
) (
   input  logic            clk,
   input  logic            res,
   input  logic            zpos,
   input  logic            wait_n,
   input  logic            vdos,
   input  logic            intack,
   input  logic [NSRC-1:0] int_start,
   input  logic [NSRC-1:0] int_clr,
   input  logic [NSRC-1:0] intmask,
   output logic [NSRC-1:0] pending,
   output logic [SW-1:0]   int_sel,
   output logic [7:0]      im2vect,
   output logic            boost_start,
   output wire logic       int_n
);

   localparam logic [7:0] PLEN = 8'(PULSE_LEN);

   logic            intack_r;
   logic            wait_r;
   logic [7:0]      cnt [NSRC];
   logic [SW-1:0]   sel_nxt;
   logic            ack_ok;
   logic [NSRC-1:0] start_ok;
   logic [NSRC-1:0] ack_hit;
   logic [NSRC-1:0] expiry;
   logic [NSRC-1:0] cnt_inc;

   // Lowest pending index wins; scanning downward leaves the lowest one last.
   always_comb begin
      sel_nxt = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (pending[i]) sel_nxt = SW'(i);
      end
   end

   assign ack_ok = intack & ~intack_r & ~vdos & (|pending);

   // Expiry only counts when no higher-priority update takes the source.
   always_comb begin
      start_ok = '0;
      ack_hit  = '0;
      expiry   = '0;
      cnt_inc  = '0;
      for (int i = 0; i < NSRC; i++) begin
         start_ok[i] = int_start[i] & ~(vdos & VDOS_LOSE[i]);
         ack_hit[i]  = ack_ok & (sel_nxt == SW'(i));
         expiry[i]   = intmask[i] & ~start_ok[i] & ~int_clr[i] & ~ack_hit[i] &
                       PULSE_MASK[i] & pending[i] & (cnt[i] == PLEN);
         cnt_inc[i]  = PULSE_MASK[i] & pending[i] & zpos & ~wait_r & ~vdos &
                       (cnt[i] < PLEN);
      end
   end

   always_ff @(posedge clk) begin
      if (res) begin
         intack_r    <= 1'b0;
         wait_r      <= 1'b0;
         int_sel     <= '0;
         boost_start <= 1'b0;
         pending     <= '0;
         for (int i = 0; i < NSRC; i++) cnt[i] <= '0;
      end else begin
         intack_r    <= intack;
         wait_r      <= ~wait_n;
         boost_start <= ack_ok | (|expiry);
         if (ack_ok) int_sel <= sel_nxt;
         for (int i = 0; i < NSRC; i++) begin
            if (!intmask[i]) begin
               pending[i] <= 1'b0;
               cnt[i]     <= '0;
            end else if (start_ok[i]) begin
               pending[i] <= 1'b1;
               cnt[i]     <= '0;
            end else if (int_clr[i] || ack_hit[i] || expiry[i]) begin
               pending[i] <= 1'b0;
            end else if (cnt_inc[i]) begin
               cnt[i] <= cnt[i] + 8'd1;
            end
         end
      end
   end

   assign im2vect = VECT_BASE - 8'(VECT_STEP * int_sel);
   assign int_n   = ((|pending) && !vdos) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_zint_pri.sv
// Directed bench for zint_pri: single-cycle vector table plus pulse-width,
// wait-extension and 8-source vector sequences.
module tb_zint_pri;

   logic       clk = 1'b0;
   logic       res, zpos, wait_n, vdos, intack;
   logic [3:0] int_start, int_clr, intmask;
   logic [3:0] pending;
   logic [1:0] int_sel;
   logic [7:0] im2vect;
   logic       boost_start;
   wire        int_n_w;

   logic       intack8;
   logic [7:0] int_start8, int_clr8, intmask8, pending8;
   logic [2:0] int_sel8;
   logic [7:0] im2vect8;
   logic       boost8;
   wire        int_n8_w;

   int checks   = 0;
   int failures = 0;

   pullup (int_n_w);
   pullup (int_n8_w);

   always #5 clk = ~clk;

   zint_pri u_dut (
      .clk(clk), .res(res), .zpos(zpos), .wait_n(wait_n), .vdos(vdos),
      .intack(intack), .int_start(int_start), .int_clr(int_clr),
      .intmask(intmask), .pending(pending), .int_sel(int_sel),
      .im2vect(im2vect), .boost_start(boost_start), .int_n(int_n_w)
   );

   zint_pri #(.NSRC(8), .VECT_BASE(8'hFE), .VECT_STEP(2)) u_dut8 (
      .clk(clk), .res(res), .zpos(zpos), .wait_n(wait_n), .vdos(vdos),
      .intack(intack8), .int_start(int_start8), .int_clr(int_clr8),
      .intmask(intmask8), .pending(pending8), .int_sel(int_sel8),
      .im2vect(im2vect8), .boost_start(boost8), .int_n(int_n8_w)
   );

   typedef struct {
      logic       res, vdos, intack;
      logic [3:0] start, clr, mask;
      logic [3:0] e_pend;
      logic       e_int_n;
      logic [1:0] e_sel;
      logic [7:0] e_vect;
      logic       e_boost;
   } vec_t;

   vec_t vt[$];

   task automatic add(input logic r, input logic vd, input logic ack,
                      input logic [3:0] st, input logic [3:0] cl, input logic [3:0] mk,
                      input logic [3:0] ep, input logic en, input logic [1:0] es,
                      input logic [7:0] ev, input logic eb);
      vec_t v;
      v.res = r; v.vdos = vd; v.intack = ack; v.start = st; v.clr = cl; v.mask = mk;
      v.e_pend = ep; v.e_int_n = en; v.e_sel = es; v.e_vect = ev; v.e_boost = eb;
      vt.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      res = 1'b0; zpos = 1'b0; wait_n = 1'b1; vdos = 1'b0; intack = 1'b0;
      int_start = '0; int_clr = '0; intmask = 4'hF;
      intack8 = 1'b0; int_start8 = '0; int_clr8 = '0; intmask8 = 8'hFF;
   endtask

   // Fires start[0] and runs zpos every 4 clk; wait_n is held low across
   // zpos pulses numbered [wait_from, wait_from+wait_cnt).
   task automatic run_pulse(input int wait_from, input int wait_cnt,
                            output int ticks, output int boosts);
      int zseen;
      ticks = 0; boosts = 0; zseen = 0;
      int_start = 4'b0001;
      @(negedge clk);
      int_start = 4'b0000;
      for (int c = 0; c < 240; c++) begin
         if (boost_start === 1'b1) boosts++;
         if (c % 4 == 0)
            wait_n = !(zseen >= wait_from && zseen < wait_from + wait_cnt);
         zpos = (c % 4 == 3);
         if (zpos) begin
            zseen++;
            if (int_n_w === 1'b0) ticks++;
         end
         @(negedge clk);
      end
      zpos = 1'b0; wait_n = 1'b1;
      if (boost_start === 1'b1) boosts++;
   endtask

   initial begin
      int ticks, boosts;
      idle_inputs();
      res = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_pending", 32'(pending), 32'h0);
      chk("reset_int_sel", 32'(int_sel), 32'h0);
      chk("reset_im2vect", 32'(im2vect), 32'hFF);
      chk("reset_boost", 32'(boost_start), 32'h0);
      chk("reset_int_n", 32'(int_n_w), 32'h1);
      res = 1'b0;
      @(negedge clk);

      //   res vdos ack start    clr      mask     pend     int_n sel vect   boost
      add(0, 0, 0, 4'b0110, 4'b0000, 4'b1111, 4'b0110, 0, 0, 8'hFF, 0);
      add(0, 0, 1, 4'b0000, 4'b0000, 4'b1111, 4'b0100, 0, 1, 8'hFD, 1);
      add(0, 0, 0, 4'b0000, 4'b0000, 4'b1111, 4'b0100, 0, 1, 8'hFD, 0);
      add(0, 0, 1, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 1, 2, 8'hFB, 1);
      add(0, 0, 1, 4'b0001, 4'b0000, 4'b1111, 4'b0001, 0, 2, 8'hFB, 0);
      add(0, 0, 0, 4'b0000, 4'b0000, 4'b1111, 4'b0001, 0, 2, 8'hFB, 0);
      add(0, 0, 1, 4'b0001, 4'b0000, 4'b1111, 4'b0001, 0, 0, 8'hFF, 1);
      add(0, 0, 0, 4'b0000, 4'b0001, 4'b1111, 4'b0000, 1, 0, 8'hFF, 0);
      add(0, 0, 0, 4'b1000, 4'b0000, 4'b0111, 4'b0000, 1, 0, 8'hFF, 0);
      add(0, 0, 0, 4'b1000, 4'b0000, 4'b1111, 4'b1000, 0, 0, 8'hFF, 0);
      add(0, 0, 0, 4'b0000, 4'b0000, 4'b0111, 4'b0000, 1, 0, 8'hFF, 0);
      add(0, 1, 0, 4'b0101, 4'b0000, 4'b1111, 4'b0100, 1, 0, 8'hFF, 0);
      add(0, 1, 1, 4'b0000, 4'b0000, 4'b1111, 4'b0100, 1, 0, 8'hFF, 0);
      add(0, 0, 0, 4'b0000, 4'b0000, 4'b1111, 4'b0100, 0, 0, 8'hFF, 0);
      add(0, 0, 1, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 1, 2, 8'hFB, 1);
      add(0, 0, 0, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 1, 2, 8'hFB, 0);
      add(0, 0, 1, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 1, 2, 8'hFB, 0);
      add(0, 1, 0, 4'b1000, 4'b0000, 4'b1111, 4'b1000, 1, 2, 8'hFB, 0);
      add(0, 0, 0, 4'b0000, 4'b0000, 4'b1111, 4'b1000, 0, 2, 8'hFB, 0);
      add(1, 0, 0, 4'b0001, 4'b0000, 4'b1111, 4'b0000, 1, 0, 8'hFF, 0);
      add(0, 0, 0, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 1, 0, 8'hFF, 0);

      foreach (vt[k]) begin
         res = vt[k].res; vdos = vt[k].vdos; intack = vt[k].intack;
         int_start = vt[k].start; int_clr = vt[k].clr; intmask = vt[k].mask;
         @(negedge clk);
         chk($sformatf("v%0d_pending", k), 32'(pending), 32'(vt[k].e_pend));
         chk($sformatf("v%0d_int_n", k), 32'(int_n_w), 32'(vt[k].e_int_n));
         chk($sformatf("v%0d_int_sel", k), 32'(int_sel), 32'(vt[k].e_sel));
         chk($sformatf("v%0d_im2vect", k), 32'(im2vect), 32'(vt[k].e_vect));
         chk($sformatf("v%0d_boost", k), 32'(boost_start), 32'(vt[k].e_boost));
      end
      idle_inputs();
      @(negedge clk);

      run_pulse(1000, 0, ticks, boosts);
      chk("pulse_ticks", 32'(ticks), 32'd32);
      chk("pulse_boosts", 32'(boosts), 32'd1);
      chk("pulse_pending", 32'(pending), 32'h0);
      chk("pulse_int_n", 32'(int_n_w), 32'h1);

      run_pulse(8, 10, ticks, boosts);
      chk("wait_ticks", 32'(ticks), 32'd42);
      chk("wait_boosts", 32'(boosts), 32'd1);
      chk("wait_pending", 32'(pending), 32'h0);

      int_start8 = 8'h80;
      @(negedge clk);
      int_start8 = 8'h00;
      chk("n8_pending", 32'(pending8), 32'h80);
      chk("n8_int_n", 32'(int_n8_w), 32'h0);
      intack8 = 1'b1;
      @(negedge clk);
      chk("n8_int_sel", 32'(int_sel8), 32'd7);
      chk("n8_im2vect", 32'(im2vect8), 32'hF0);
      chk("n8_pending_after", 32'(pending8), 32'h0);
      chk("n8_boost", 32'(boost8), 32'h1);
      intack8 = 1'b0;
      @(negedge clk);
      chk("n8_int_n_after", 32'(int_n8_w), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
